ofm_write_addr_controller: RTL and testbench
============================================

// Module: ofm_write_addr_controller
// PURPOSE
//   Write-side counterpart of the IFM read address generator. After the systolic array finishes a
//   tile (one OFM row segment of `size` pixels x NUM_FILTER filters), this block sequences the writes
//   into the OFM buffer. It emits one write address per cycle plus the filter/pixel select for the
//   result mux, optionally applying 2x nearest-neighbour upsampling. It also tracks tile position across the layer.
// PARAMETERS
//   SYSTOLIC_SIZE  16  max pixels per tile row segment (column tile width)
//   OFM_SIZE       13  conv output height/width (square)
//   NUM_FILTER     16  filters produced per tile (OFM channels in this buffer)
//   UPSAMPLE       1   1: write each pixel to a 2x2 block of a 2*OFM_SIZE map; 0: direct write
//   ADDR_WIDTH     14  OFM buffer address width
// PORTS
//   clk         in   1           clock
//   rst         in   1           synchronous reset, active-high
//   start       in   1           1-cycle pulse: tile results ready; ignored while busy
//   size        in   5           valid pixels in this tile (1..SYSTOLIC_SIZE), sampled on accepted start
//   ofm_addr    out  ADDR_WIDTH  write address
//   write_en    out  1           ofm_addr/filt_idx/pix_idx valid this cycle
//   filt_idx    out  $clog2(NUM_FILTER)     filter select for result mux
//   pix_idx     out  $clog2(SYSTOLIC_SIZE)  pixel (PE column) select for result mux
//   busy        out  1           high from accepted start until done
//   done        out  1           1-cycle pulse after last write of a tile
//   layer_done  out  1           1-cycle pulse coincident with done of the final tile of the layer
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; tile_row=0, col_base=0, all counters 0. Reset mid-tile aborts
//   with no further writes and restarts at layer origin.
//   OUT_DIM = UPSAMPLE ? 2*OFM_SIZE : OFM_SIZE. Channel-major layout: addr = f*OUT_DIM^2 + r*OUT_DIM + c.
//   FSM: IDLE --start--> WRITE --last write--> DONE --> IDLE (DONE lasts exactly 1 cycle).
//   start accepted only in IDLE; size latched then. size==0: WRITE skipped, IDLE->DONE, no writes.
//   Latency: start at cycle t -> first write_en at t+1; one write every cycle, no gaps.
//   Write order: filter f outer (0..NUM_FILTER-1), pixel p (0..size-1), then sub-position inner.
//   UPSAMPLE=0: one write for pixel p: r=tile_row, c=col_base+p.
//   UPSAMPLE=1: four writes for pixel p: (2R,2C),(2R,2C+1),(2R+1,2C),(2R+1,2C+1);
//     R=tile_row, C=col_base+p.
//   Writes per tile = NUM_FILTER*size*(UPSAMPLE?4:1); done asserted the cycle after the last write.
//   busy is 1 in WRITE and DONE.
//   Address computed incrementally (adds only, no runtime multiply). Products of parameters are
//   constants. The address must not wrap: OUT_DIM^2*NUM_FILTER <= 2^ADDR_WIDTH (parameter check).
//   Tile advance in DONE:
//     tile_row==OFM_SIZE-1 -> tile_row=0, col_base+=SYSTOLIC_SIZE.
//     When col_base+size==OFM_SIZE also holds (last tile of the layer): col_base=0 and layer_done=1.
//     Otherwise tile_row+=1.
//   size is trusted. Values >SYSTOLIC_SIZE are undefined; values that would pass OFM_SIZE are undefined.
//   start arriving in the same cycle as DONE is ignored; producer must re-pulse after busy falls.
// TESTING
//   1 Reset then idle: all outputs 0 for 10 cycles; start during rst=1 -> no write_en.
//   2 UPSAMPLE=1,OFM=13,NF=16, start size=13 at tile 0:
//     addrs 0,1,26,27,2,3,28,29...; f=1 first addr 676; 832 writes; done at t+833.
//   3 Same config, 6th tile (tile_row=5): first four addrs 260,261,286,287; pix_idx 0 held for 4 cycles.
//   4 UPSAMPLE=0, size=13: addrs 0..12 then 169..181...; 208 writes.
//     Start pulses while busy are ignored (count unchanged).
//   5 UPSAMPLE=0, OFM=20: after 20 tiles of size 16, tile 21 has size=4 and first addr 16.
//     layer_done on tile 40; tile 41 first addr 0.
//   6 Assert rst mid-WRITE: next cycle write_en=0, busy=0. The following start writes from addr 0.

Source files
------------

// File: rtl/ofm_write_addr_controller.sv
// OFM buffer write sequencer: emits one write address per cycle for a finished tile,
// with optional 2x nearest-neighbour upsampling, and tracks tile position across the layer.
// state | meaning
// IDLE  | waiting for start
// WRITE | one buffer write per cycle, filter-major, pixel, then sub-position
// DONE  | one-cycle tile completion; tile position advances
module ofm_write_addr_controller #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_SIZE      = 13,
    parameter int NUM_FILTER    = 16,
    parameter int UPSAMPLE      = 1,
    parameter int ADDR_WIDTH    = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [4:0]                       size,
    output logic [ADDR_WIDTH-1:0]            ofm_addr,
    output logic                             write_en,
    output logic [$clog2(NUM_FILTER)-1:0]    filt_idx,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0] pix_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             layer_done
);
    localparam int FW       = $clog2(NUM_FILTER);
    localparam int PW       = $clog2(SYSTOLIC_SIZE);
    localparam int RW       = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int CW       = $clog2(OFM_SIZE + SYSTOLIC_SIZE + 1);
    localparam int OUT_DIM  = (UPSAMPLE != 0) ? 2 * OFM_SIZE : OFM_SIZE;
    localparam int PLANE    = OUT_DIM * OUT_DIM;
    localparam int ROW_STEP = (UPSAMPLE != 0) ? 2 * OUT_DIM : OUT_DIM;
    localparam int PIX_STEP = (UPSAMPLE != 0) ? 2 : 1;

    localparam logic [ADDR_WIDTH-1:0] DIM_A      = ADDR_WIDTH'(OUT_DIM);
    localparam logic [ADDR_WIDTH-1:0] PLANE_A    = ADDR_WIDTH'(PLANE);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP_A = ADDR_WIDTH'(ROW_STEP);
    localparam logic [ADDR_WIDTH-1:0] PIX_STEP_A = ADDR_WIDTH'(PIX_STEP);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP_A = ADDR_WIDTH'(SYSTOLIC_SIZE * PIX_STEP);

    if ((64'(PLANE) * 64'(NUM_FILTER)) > (64'd1 << ADDR_WIDTH)) begin : g_addr_range_check
        $error("ofm_write_addr_controller: OFM map does not fit in ADDR_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [4:0]            size_q;
    logic [FW-1:0]         f_cnt;
    logic [PW-1:0]         p_cnt;
    logic [1:0]            s_cnt;
    logic [ADDR_WIDTH-1:0] filt_base;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [RW-1:0]         tile_row;
    logic [CW-1:0]         col_base;
    logic [ADDR_WIDTH-1:0] row_off;
    logic [ADDR_WIDTH-1:0] col_off;
    logic [ADDR_WIDTH-1:0] tile_base;

    logic sub_last, pix_last, filt_last, row_last, last_tile;

    assign tile_base = row_off + col_off;
    assign sub_last  = (UPSAMPLE == 0) || (s_cnt == 2'd3);
    assign pix_last  = (5'(p_cnt) == (size_q - 5'd1));
    assign filt_last = (f_cnt == FW'(NUM_FILTER - 1));
    assign row_last  = (tile_row == RW'(OFM_SIZE - 1));
    assign last_tile = row_last &&
                       (({1'b0, col_base} + (CW+1)'(size_q)) == (CW+1)'(OFM_SIZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (size == 5'd0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (sub_last && pix_last && filt_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address is kept as a running base per pixel; sub-position offsets are added at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_q    <= '0;
            f_cnt     <= '0;
            p_cnt     <= '0;
            s_cnt     <= '0;
            filt_base <= '0;
            pix_addr  <= '0;
            tile_row  <= '0;
            col_base  <= '0;
            row_off   <= '0;
            col_off   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        size_q    <= size;
                        f_cnt     <= '0;
                        p_cnt     <= '0;
                        s_cnt     <= '0;
                        filt_base <= '0;
                        pix_addr  <= tile_base;
                    end
                end
                WRITE: begin
                    if (sub_last) begin
                        s_cnt <= '0;
                        if (pix_last) begin
                            p_cnt     <= '0;
                            f_cnt     <= f_cnt + FW'(1);
                            filt_base <= filt_base + PLANE_A;
                            pix_addr  <= filt_base + PLANE_A + tile_base;
                        end else begin
                            p_cnt    <= p_cnt + PW'(1);
                            pix_addr <= pix_addr + PIX_STEP_A;
                        end
                    end else begin
                        s_cnt <= s_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (row_last) begin
                        tile_row <= '0;
                        row_off  <= '0;
                        if (last_tile) begin
                            col_base <= '0;
                            col_off  <= '0;
                        end else begin
                            col_base <= col_base + CW'(SYSTOLIC_SIZE);
                            col_off  <= col_off + COL_STEP_A;
                        end
                    end else begin
                        tile_row <= tile_row + RW'(1);
                        row_off  <= row_off + ROW_STEP_A;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        write_en   = (state == WRITE);
        busy       = (state == WRITE) || (state == DONE);
        done       = (state == DONE);
        layer_done = (state == DONE) && last_tile;
        ofm_addr   = '0;
        filt_idx   = '0;
        pix_idx    = '0;
        if (state == WRITE) begin
            ofm_addr = pix_addr + (s_cnt[1] ? DIM_A : '0) + ADDR_WIDTH'(s_cnt[0]);
            filt_idx = f_cnt;
            pix_idx  = p_cnt;
        end
    end

endmodule

// File: tb/tb_ofm_write_addr_controller.sv
// Scoreboard bench: three controller configurations share clock/reset; stimulus pushes
// expected writes, a monitor pops and compares each presented write.
module tb_ofm_write_addr_controller;
    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [4:0]  size;
    logic [13:0] addr [3];
    logic [3:0]  fi [3];
    logic [3:0]  pi [3];
    logic [2:0]  we, busy, done, ldone;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [21:0] exp_q [3][$];
    int          log_q [3][$];
    int          wr_cnt [3];
    int          first_wr [3];

    int up_m  [3] = '{1, 0, 0};
    int ofm_m [3] = '{13, 13, 20};
    int row_m [3] = '{0, 0, 0};
    int col_m [3] = '{0, 0, 0};

    ofm_write_addr_controller #(.SYSTOLIC_SIZE(16), .OFM_SIZE(13), .NUM_FILTER(16),
                                .UPSAMPLE(1), .ADDR_WIDTH(14)) u_up13 (
        .clk(clk), .rst(rst), .start(start[0]), .size(size), .ofm_addr(addr[0]),
        .write_en(we[0]), .filt_idx(fi[0]), .pix_idx(pi[0]), .busy(busy[0]),
        .done(done[0]), .layer_done(ldone[0]));

    ofm_write_addr_controller #(.SYSTOLIC_SIZE(16), .OFM_SIZE(13), .NUM_FILTER(16),
                                .UPSAMPLE(0), .ADDR_WIDTH(14)) u_dir13 (
        .clk(clk), .rst(rst), .start(start[1]), .size(size), .ofm_addr(addr[1]),
        .write_en(we[1]), .filt_idx(fi[1]), .pix_idx(pi[1]), .busy(busy[1]),
        .done(done[1]), .layer_done(ldone[1]));

    ofm_write_addr_controller #(.SYSTOLIC_SIZE(16), .OFM_SIZE(20), .NUM_FILTER(16),
                                .UPSAMPLE(0), .ADDR_WIDTH(14)) u_dir20 (
        .clk(clk), .rst(rst), .start(start[2]), .size(size), .ofm_addr(addr[2]),
        .write_en(we[2]), .filt_idx(fi[2]), .pix_idx(pi[2]), .busy(busy[2]),
        .done(done[2]), .layer_done(ldone[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint got, input longint expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [21:0] e;
        for (int k = 0; k < 3; k++) begin
            if (we[k] === 1'b1) begin
                wr_cnt[k]++;
                if (first_wr[k] < 0) first_wr[k] = cyc;
                log_q[k].push_back(int'(addr[k]));
                if (exp_q[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write dut=%0d got addr=%0d f=%0d p=%0d",
                             k, addr[k], fi[k], pi[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("wr dut%0d addr/f/p(packed)", k), {addr[k], fi[k], pi[k]}, e);
                end
            end
        end
    end

    // Expected writes straight from addr = f*D^2 + r*D + c.
    task automatic push_tile(input int k, input int sz);
        int d, ns, r, c, a;
        d  = (up_m[k] != 0) ? 2 * ofm_m[k] : ofm_m[k];
        ns = (up_m[k] != 0) ? 4 : 1;
        for (int f = 0; f < 16; f++)
            for (int p = 0; p < sz; p++)
                for (int s = 0; s < ns; s++) begin
                    r = (up_m[k] != 0) ? 2 * row_m[k] + s / 2 : row_m[k];
                    c = (up_m[k] != 0) ? 2 * (col_m[k] + p) + s % 2 : col_m[k] + p;
                    a = f * d * d + r * d + c;
                    exp_q[k].push_back({14'(a), 4'(f), 4'(p)});
                end
    endtask

    task automatic advance(input int k, input int sz, output bit ld);
        ld = 1'b0;
        if (row_m[k] == ofm_m[k] - 1) begin
            row_m[k] = 0;
            if (col_m[k] + sz == ofm_m[k]) begin
                col_m[k] = 0;
                ld = 1'b1;
            end else begin
                col_m[k] += 16;
            end
        end else begin
            row_m[k]++;
        end
    endtask

    task automatic run_tile(input int k, input int sz, input bit poke,
                            output int t0, output int tdone, output bit ld);
        push_tile(k, sz);
        first_wr[k] = -1;
        wr_cnt[k]   = 0;
        log_q[k].delete();
        @(negedge clk);
        size = 5'(sz);
        start[k] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start[k] = 1'b0;
        tdone = -1;
        ld = 1'b0;
        for (int i = 0; i < 1000 && tdone < 0; i++) begin
            start[k] = poke && (i == 20 || i == 100);
            if (done[k] === 1'b1) begin
                tdone = cyc;
                ld = ldone[k];
            end else begin
                @(negedge clk);
            end
        end
        start[k] = 1'b0;
        if (tdone < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout dut=%0d got no done expected within 1000 cycles", k);
        end
        chk($sformatf("queue_drained dut%0d", k), exp_q[k].size(), 0);
    endtask

    function automatic int log_at(input int k, input int i);
        return (log_q[k].size() > i) ? log_q[k][i] : -1;
    endfunction

    initial begin
        int t0, td, tcount;
        bit ld, eld, sz;
        int tsz;
        int exp2 [8] = '{0, 1, 26, 27, 2, 3, 28, 29};
        int exp3 [4] = '{260, 261, 286, 287};

        for (int k = 0; k < 3; k++) begin
            wr_cnt[k] = 0;
            first_wr[k] = -1;
        end
        rst = 1'b1;
        start = 3'b000;
        size = 5'd0;

        // reset with start held high: nothing must be written
        repeat (2) @(negedge clk);
        start = 3'b111;
        size = 5'd13;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_write_en", we, 0);
        end
        start = 3'b000;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_write_en", we, 0);
            chk("idle_status", {busy, done, ldone}, 0);
            chk("idle_addr_idx", addr[0] | addr[1] | addr[2] | 14'(fi[0] | fi[1] | fi[2] | pi[0] | pi[1] | pi[2]), 0);
        end

        // upsampled tile 0
        run_tile(0, 13, 1'b0, t0, td, ld);
        chk("t2_first_write_latency", first_wr[0] - t0, 1);
        chk("t2_done_latency", td - t0, 833);
        chk("t2_write_count", wr_cnt[0], 832);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_addr[%0d]", i), log_at(0, i), exp2[i]);
        chk("t2_filter1_first_addr", log_at(0, 52), 676);
        advance(0, 13, eld);
        chk("t2_layer_done", ld, 0);

        for (int n = 1; n < 5; n++) begin
            run_tile(0, 13, 1'b0, t0, td, ld);
            advance(0, 13, eld);
            chk("up_tile_layer_done", ld, eld);
        end
        run_tile(0, 13, 1'b0, t0, td, ld);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_addr[%0d]", i), log_at(0, i), exp3[i]);
        advance(0, 13, eld);

        // direct tile with extra start pulses during WRITE, then one in the DONE cycle
        run_tile(1, 13, 1'b1, t0, td, ld);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_write_count", wr_cnt[1], 208);
        chk("t4_done_latency", td - t0, 209);
        chk("t4_addr12", log_at(1, 12), 12);
        chk("t4_addr13", log_at(1, 13), 169);
        chk("t4_start_in_done_ignored_busy", busy[1], 0);
        advance(1, 13, eld);

        run_tile(1, 0, 1'b0, t0, td, ld);
        chk("size0_done_latency", td - t0, 1);
        chk("size0_write_count", wr_cnt[1], 0);
        advance(1, 0, eld);

        // OFM=20 layer walk: 20 tiles of 16, 20 tiles of 4, wrap
        for (int n = 1; n <= 41; n++) begin
            tsz = (col_m[2] == 0) ? 16 : 4;
            run_tile(2, tsz, 1'b0, t0, td, ld);
            advance(2, tsz, eld);
            chk($sformatf("t5_layer_done tile%0d", n), ld, (n == 40) ? 1 : 0);
            if (n == 21) chk("t5_tile21_first_addr", log_at(2, 0), 16);
            if (n == 41) chk("t5_tile41_first_addr", log_at(2, 0), 0);
        end

        // reset in the middle of a WRITE
        push_tile(0, 13);
        wr_cnt[0] = 0;
        @(negedge clk);
        size = 5'd13;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        chk("t6_writes_before_reset", wr_cnt[0], 20);
        exp_q[0].delete();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_write_en_after_reset", we[0], 0);
        chk("t6_busy_after_reset", busy[0], 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            row_m[k] = 0;
            col_m[k] = 0;
        end
        run_tile(0, 13, 1'b0, t0, td, ld);
        chk("t6_restart_first_addr", log_at(0, 0), 0);
        chk("t6_restart_latency", first_wr[0] - t0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
